score_scan_display: RTL
=======================

SCORE_SCAN_DISPLAY -- requirements
Module: score_scan_display

Interface
REQ-001 SHALL have parameter DIGITS, default 4, number of BCD score digits (legal 1..8).
REQ-002 SHALL have parameter SCAN_DIV, default 50000, clk_50m cycles per digit-scan step (legal >=2).
REQ-003 SHALL have parameter SAT, default 1, 1 = saturate at all-9s, 0 = wrap to zero.
REQ-004 SHALL have port clk_50m  in  1  sole clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-006 SHALL have port score_tick  in  1  single-cycle enable pulse, +1 to score.
REQ-007 SHALL have port pause  in  1  level, freezes scoring.
REQ-008 SHALL have port endgame  in  1  level, ends the game.
REQ-009 SHALL have port new_game  in  1  single-cycle pulse, restarts scoring and keeps best.
REQ-010 SHALL have port show_best  in  1  level, display best instead of score.
REQ-011 SHALL have port score  out  4*DIGITS  current score, packed BCD, digit 0 at LSBs.
REQ-012 SHALL have port best  out  4*DIGITS  best score, packed BCD.
REQ-013 SHALL have port game_over  out  1  high in state OVER.
REQ-014 SHALL have port seg  out  8  active-low segments {dp,g,f,e,d,c,b,a}.
REQ-015 SHALL have port an  out  DIGITS  active-low digit enables, exactly one low.

Function
REQ-016 SHALL implement states RUN, PAUSED, OVER.
REQ-017 RUN -> OVER on endgame; RUN -> PAUSED on pause; PAUSED -> RUN on !pause; PAUSED -> OVER on endgame; OVER is held until new_game or rst.
REQ-018 Priority per cycle SHALL be rst > new_game > endgame > pause > score_tick.
REQ-019 new_game SHALL set score to 0 and state to RUN next cycle, from any state, with best unchanged.
REQ-020 score_tick SHALL increment score only in RUN with endgame=0 and pause=0, and is ignored otherwise.
REQ-021 score SHALL update exactly one cycle after the qualifying tick.
REQ-022 Increment SHALL be decimal with ripple carry, so digit 9 -> 0 and +1 goes to the next digit.
REQ-023 At all-9s, SAT=1 SHALL hold the score and SAT=0 SHALL wrap the score to 0.
REQ-024 On the cycle of entering OVER, best SHALL be loaded with score if score > best (BCD compare); the pre-tick score is used.
REQ-025 Scan counter SHALL count 0..SCAN_DIV-1; on wrap the digit index SHALL advance 0..DIGITS-1 and wrap to 0.
REQ-026 an SHALL be low only at bit = digit index.
REQ-027 seg SHALL show the selected digit of (show_best ? best : score).
REQ-028 seg and an SHALL be registered, 1 cycle after an index or value change.
REQ-029 Leading-zero blanking: digits above the most significant nonzero digit SHALL be all-off (8'hFF); digit 0 is always shown.
REQ-030 dp SHALL be lit on digit 0 when game_over=1, and on digit DIGITS-1 when show_best=1; otherwise dp is off.
REQ-031 BCD nibble values 10..15 SHALL never occur; if forced, the digit SHALL be blanked.

Reset
REQ-032 rst SHALL clear: score=0, best=0, state RUN, game_over=0, scan counter 0, digit index 0.
REQ-033 On the cycle after rst, an SHALL be ~1 (only bit 0 low) and seg SHALL show "0" (8'hC0).
REQ-034 rst mid-scan or mid-count SHALL abort cleanly, with no carry completing after reset.

Structure
REQ-035 Shared package score_pkg SHALL hold the state encoding, the seven-segment constants for 0-9, and the blank pattern 8'hFF.
REQ-036 SHALL instantiate one combinational sub-module bcd_to_seg (4-bit BCD in, 7-bit active-low out).
REQ-037 All other logic SHALL be in score_scan_display.

Verification (DIGITS=4, SCAN_DIV=4 unless stated)
REQ-038 Sequence: rst, then 123 ticks -> score=16'h0123; an cycles 1110,1101,1011,0111 every 4 cycles; digit 3 is blank.
REQ-039 Sequence: score 0999 plus 1 tick -> 16'h1000 one cycle later; with SAT=1, 9999 plus ticks holds at 9999; with SAT=0, 9999 plus 1 tick -> 0000.
REQ-040 Sequence: pause=1 for 10 ticks -> score unchanged, state PAUSED; release pause, then 1 tick -> +1.
REQ-041 Sequence: score 0042, then endgame with a simultaneous tick -> game_over=1, best=0042, score stays 0042, dp lit on digit 0.
REQ-042 Sequence: new_game, 30 ticks, then endgame -> best stays 0042; new_game, 50 ticks, then endgame -> best=0050; show_best=1 shows "50" with dp on digit 3.
REQ-043 Sequence: rst asserted during a scan step and a carry -> all outputs at their reset values next cycle; new_game and endgame in the same cycle -> RUN with score 0.

Source files
------------

// File: rtl/score_pkg.sv
// Shared definitions for the score counter and its multiplexed seven-segment display.
package score_pkg;

  // Game state encoding.
  typedef enum logic [1:0] {
    RUN    = 2'd0,
    PAUSED = 2'd1,
    OVER   = 2'd2
  } state_t;

  // Active-low segment patterns {dp,g,f,e,d,c,b,a} for decimal digits 0..9, dp off.
  localparam logic [7:0] SEG_DIGIT [0:9] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
    8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
  };

  // Every segment and the decimal point dark.
  localparam logic [7:0] SEG_BLANK = 8'hFF;

endpackage

// File: rtl/score_scan_display_bcd_to_seg.sv
// Combinational BCD digit to active-low seven-segment decoder; non-decimal codes go dark.
module bcd_to_seg
  import score_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  // Table lookup; codes 10..15 fall through to the blank pattern.
  always_comb begin
    seg = SEG_BLANK[6:0];
    case (bcd)
      4'd0: seg = SEG_DIGIT[0][6:0];
      4'd1: seg = SEG_DIGIT[1][6:0];
      4'd2: seg = SEG_DIGIT[2][6:0];
      4'd3: seg = SEG_DIGIT[3][6:0];
      4'd4: seg = SEG_DIGIT[4][6:0];
      4'd5: seg = SEG_DIGIT[5][6:0];
      4'd6: seg = SEG_DIGIT[6][6:0];
      4'd7: seg = SEG_DIGIT[7][6:0];
      4'd8: seg = SEG_DIGIT[8][6:0];
      4'd9: seg = SEG_DIGIT[9][6:0];
      default: seg = SEG_BLANK[6:0];
    endcase
  end

endmodule

// File: rtl/score_scan_display.sv
// BCD game score with best-score capture and a time-multiplexed seven-segment display.
module score_scan_display
  import score_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 50000,
  parameter int SAT      = 1
) (
  input  logic                  clk_50m,
  input  logic                  rst,
  input  logic                  score_tick,
  input  logic                  pause,
  input  logic                  endgame,
  input  logic                  new_game,
  input  logic                  show_best,
  output logic [4*DIGITS-1:0]   score,
  output logic [4*DIGITS-1:0]   best,
  output logic                  game_over,
  output logic [7:0]            seg,
  output logic [DIGITS-1:0]     an
);

  localparam int W     = 4 * DIGITS;
  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  state_t           state, state_next;
  logic [W-1:0]     score_q, score_next;
  logic [W-1:0]     best_q, best_next;
  logic [CNT_W-1:0] scan_cnt;
  logic [IDX_W-1:0] digit_idx;
  logic [W-1:0]     disp_val;
  logic [IDX_W-1:0] msd;
  logic [3:0]       cur_nib;
  logic [6:0]       seg7;
  logic             blank;
  logic             dp_on;
  logic [7:0]       seg_next;
  logic [DIGITS-1:0] an_next;
  logic [7:0]       seg_q;
  logic [DIGITS-1:0] an_q;

  // Decimal +1 with ripple carry; an all-9s score either holds or rolls to zero.
  function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (v[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    if (carry && (SAT != 0)) r = v;
    return r;
  endfunction

  // Game FSM and score/best next values; new_game outranks endgame, which outranks pause, then tick.
  always_comb begin
    state_next = state;
    score_next = score_q;
    best_next  = best_q;
    if (new_game) begin
      state_next = RUN;
      score_next = '0;
    end else begin
      case (state)
        RUN: begin
          if (endgame) begin
            state_next = OVER;
            if (score_q > best_q) best_next = score_q;
          end else if (pause) begin
            state_next = PAUSED;
          end else if (score_tick) begin
            score_next = bcd_inc(score_q);
          end
        end
        PAUSED: begin
          if (endgame) begin
            state_next = OVER;
            if (score_q > best_q) best_next = score_q;
          end else if (!pause) begin
            state_next = RUN;
          end
        end
        OVER: begin
          state_next = OVER;
        end
        default: begin
          state_next = RUN;
        end
      endcase
    end
  end

  // Game state, score and best registers.
  always_ff @(posedge clk_50m) begin
    if (rst) begin
      state   <= RUN;
      score_q <= '0;
      best_q  <= '0;
    end else begin
      state   <= state_next;
      score_q <= score_next;
      best_q  <= best_next;
    end
  end

  // Scan prescaler and digit selector; the digit steps once per SCAN_DIV cycles.
  always_ff @(posedge clk_50m) begin
    if (rst) begin
      scan_cnt  <= '0;
      digit_idx <= '0;
    end else if (scan_cnt == CNT_W'(SCAN_DIV - 1)) begin
      scan_cnt  <= '0;
      digit_idx <= (digit_idx == IDX_W'(DIGITS - 1)) ? '0 : digit_idx + 1'b1;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  // Pick the shown value, find its most significant nonzero digit and build the next segment pattern.
  always_comb begin
    disp_val = show_best ? best_q : score_q;
    msd      = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (disp_val[4*i +: 4] != 4'd0) msd = IDX_W'(i);
    end
    cur_nib  = disp_val[4*digit_idx +: 4];
    blank    = (digit_idx > msd);
    dp_on    = ((digit_idx == '0) && (state == OVER)) ||
               ((digit_idx == IDX_W'(DIGITS - 1)) && show_best);
    seg_next = {~dp_on, blank ? SEG_BLANK[6:0] : seg7};
    an_next  = ~(DIGITS'(1) << digit_idx);
  end

  bcd_to_seg u_dec (
    .bcd (cur_nib),
    .seg (seg7)
  );

  // Register the display drive so segments and anodes switch together.
  always_ff @(posedge clk_50m) begin
    if (rst) begin
      seg_q <= SEG_DIGIT[0];
      an_q  <= ~DIGITS'(1);
    end else begin
      seg_q <= seg_next;
      an_q  <= an_next;
    end
  end

  assign score     = score_q;
  assign best      = best_q;
  assign game_over = (state == OVER);
  assign seg       = seg_q;
  assign an        = an_q;

endmodule
